// File: rtl/reg_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter_pkg
// Brief    : Shared defaults and write-back priority state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package reg_write_arbiter_pkg;

    localparam int c_DATA_W  = 32;
    localparam int c_ADDR_W  = 6;
    localparam int c_REG_CNT = 32;

    typedef enum logic [0:0] {
        PRI_M = 1'b0,
        PRI_A = 1'b1
    } pri_state_t;

endpackage
`default_nettype wire

// File: rtl/reg_bypass_cmp.sv
`default_nettype none
// ============================================================================
// Module   : reg_bypass_cmp
// Brief    : Matches one read-port address against the write port in flight.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bypass_cmp
    import reg_write_arbiter_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W
) (
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rs_addr,
    output logic              o_fwd_valid,
    output logic [DATA_W-1:0] o_fwd_data
);

    logic w_hit;

    // x0 is hardwired, so it never forwards
    assign w_hit       = i_wr_en && (i_rs_addr == i_wr_addr) && (i_rs_addr != '0);
    assign o_fwd_valid = w_hit;
    assign o_fwd_data  = w_hit ? i_wr_data : '0;

endmodule
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter
// Brief    : Alternating-priority ALU/memory write-back arbiter with a
//            registered register-file write port and optional read bypass
//            (enabled by defining REG_WRITE_BYPASS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int DATA_W  = c_DATA_W,
    parameter int ADDR_W  = c_ADDR_W,
    parameter int REG_CNT = c_REG_CNT
) (
    input  logic              Clk_In,
    input  logic              Rst_In,
    input  logic              A_Valid_In,
    input  logic [ADDR_W-1:0] A_Addr_In,
    input  logic [DATA_W-1:0] A_Data_In,
    output logic              A_Ready_Out,
    input  logic              M_Valid_In,
    input  logic [ADDR_W-1:0] M_Addr_In,
    input  logic [DATA_W-1:0] M_Data_In,
    output logic              M_Ready_Out,
    input  logic              Wr_Hold_In,
    output logic              Reg_Write_flag_Out,
    output logic [ADDR_W-1:0] RD_Addr_Out,
    output logic [DATA_W-1:0] RD_Data_Out,
    output logic              Err_Out,
    output logic [15:0]       Wr_Count_Out,
    input  logic [ADDR_W-1:0] RS1_Addr_In,
    input  logic [ADDR_W-1:0] RS2_Addr_In,
    output logic              Fwd1_Valid_Out,
    output logic [DATA_W-1:0] Fwd1_Data_Out,
    output logic              Fwd2_Valid_Out,
    output logic [DATA_W-1:0] Fwd2_Data_Out
);

    pri_state_t        r_pri;
    pri_state_t        w_pri_nxt;
    logic              w_a_ready;
    logic              w_m_ready;
    logic              w_grant;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_in_range;
    logic              w_commit;
    logic              w_drop;

    logic              r_flag;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [15:0]       r_count;

    always_ff @(posedge Clk_In or posedge Rst_In) begin
        if (Rst_In) begin
            r_pri <= PRI_M;
        end else begin
            r_pri <= w_pri_nxt;
        end
    end

    // A requester loses only when the other is also valid and holds priority
    always_comb begin
        w_a_ready = 1'b0;
        w_m_ready = 1'b0;
        w_pri_nxt = r_pri;
        if (!Wr_Hold_In) begin
            w_m_ready = M_Valid_In && (!A_Valid_In || (r_pri == PRI_M));
            w_a_ready = A_Valid_In && (!M_Valid_In || (r_pri == PRI_A));
        end
        if (w_m_ready) begin
            w_pri_nxt = PRI_A;
        end else if (w_a_ready) begin
            w_pri_nxt = PRI_M;
        end
    end

    assign A_Ready_Out = w_a_ready;
    assign M_Ready_Out = w_m_ready;

    assign w_grant    = w_a_ready || w_m_ready;
    assign w_sel_addr = w_m_ready ? M_Addr_In : A_Addr_In;
    assign w_sel_data = w_m_ready ? M_Data_In : A_Data_In;
    assign w_in_range = 32'(w_sel_addr) < 32'(REG_CNT);
    assign w_commit   = w_grant && w_in_range && (w_sel_addr != '0);
    assign w_drop     = w_grant && !w_in_range;

    // Address/data only move on a real commit so the port holds its last write
    always_ff @(posedge Clk_In or posedge Rst_In) begin
        if (Rst_In) begin
            r_flag  <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_count <= '0;
        end else begin
            r_flag <= w_commit;
            r_err  <= w_drop;
            if (w_commit) begin
                r_addr  <= w_sel_addr;
                r_data  <= w_sel_data;
                r_count <= r_count + 16'd1;
            end
        end
    end

    assign Reg_Write_flag_Out = r_flag;
    assign RD_Addr_Out        = r_addr;
    assign RD_Data_Out        = r_data;
    assign Err_Out            = r_err;
    assign Wr_Count_Out       = r_count;

`ifdef REG_WRITE_BYPASS_EN
    reg_bypass_cmp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bypass_rs1 (
        .i_wr_en     (r_flag),
        .i_wr_addr   (r_addr),
        .i_wr_data   (r_data),
        .i_rs_addr   (RS1_Addr_In),
        .o_fwd_valid (Fwd1_Valid_Out),
        .o_fwd_data  (Fwd1_Data_Out)
    );

    reg_bypass_cmp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bypass_rs2 (
        .i_wr_en     (r_flag),
        .i_wr_addr   (r_addr),
        .i_wr_data   (r_data),
        .i_rs_addr   (RS2_Addr_In),
        .o_fwd_valid (Fwd2_Valid_Out),
        .o_fwd_data  (Fwd2_Data_Out)
    );
`else
    logic w_unused_rs;

    assign w_unused_rs    = ^{RS1_Addr_In, RS2_Addr_In};
    assign Fwd1_Valid_Out = 1'b0;
    assign Fwd1_Data_Out  = '0;
    assign Fwd2_Valid_Out = 1'b0;
    assign Fwd2_Data_Out  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_write_arbiter
// Brief    : Scoreboard bench for reg_write_arbiter (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

    logic        Clk_In = 1'b0;
    logic        Rst_In;
    logic        A_Valid_In, M_Valid_In, Wr_Hold_In;
    logic [5:0]  A_Addr_In, M_Addr_In, RS1_Addr_In, RS2_Addr_In;
    logic [31:0] A_Data_In, M_Data_In;
    logic        A_Ready_Out, M_Ready_Out, Reg_Write_flag_Out, Err_Out;
    logic [5:0]  RD_Addr_Out;
    logic [31:0] RD_Data_Out, Fwd1_Data_Out, Fwd2_Data_Out;
    logic [15:0] Wr_Count_Out;
    logic        Fwd1_Valid_Out, Fwd2_Valid_Out;

    reg_write_arbiter u_dut (
        .Clk_In             (Clk_In),
        .Rst_In             (Rst_In),
        .A_Valid_In         (A_Valid_In),
        .A_Addr_In          (A_Addr_In),
        .A_Data_In          (A_Data_In),
        .A_Ready_Out        (A_Ready_Out),
        .M_Valid_In         (M_Valid_In),
        .M_Addr_In          (M_Addr_In),
        .M_Data_In          (M_Data_In),
        .M_Ready_Out        (M_Ready_Out),
        .Wr_Hold_In         (Wr_Hold_In),
        .Reg_Write_flag_Out (Reg_Write_flag_Out),
        .RD_Addr_Out        (RD_Addr_Out),
        .RD_Data_Out        (RD_Data_Out),
        .Err_Out            (Err_Out),
        .Wr_Count_Out       (Wr_Count_Out),
        .RS1_Addr_In        (RS1_Addr_In),
        .RS2_Addr_In        (RS2_Addr_In),
        .Fwd1_Valid_Out     (Fwd1_Valid_Out),
        .Fwd1_Data_Out      (Fwd1_Data_Out),
        .Fwd2_Valid_Out     (Fwd2_Valid_Out),
        .Fwd2_Data_Out      (Fwd2_Data_Out)
    );

    always #5 Clk_In = ~Clk_In;

    typedef struct packed {
        logic        flag;
        logic        err;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [15:0] cnt;
    } wp_t;

    wp_t         sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // Reference state: priority, committed count, last committed write
    logic        m_pri_a;
    logic [15:0] m_cnt;
    logic [5:0]  m_addr;
    logic [31:0] m_data;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pri_a = 1'b0;
        m_cnt   = 16'd0;
        m_addr  = 6'd0;
        m_data  = 32'd0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_flag"}, Reg_Write_flag_Out, 0);
        check_val({tag, "_err"}, Err_Out, 0);
        check_val({tag, "_addr"}, RD_Addr_Out, 0);
        check_val({tag, "_data"}, RD_Data_Out, 0);
        check_val({tag, "_cnt"}, Wr_Count_Out, 0);
        check_val({tag, "_fwd"}, {Fwd1_Valid_Out, Fwd2_Valid_Out, Fwd1_Data_Out | Fwd2_Data_Out}, 0);
    endtask

    // One clock: drive at negedge, check grants, push expected write port,
    // then pop and compare after the rising edge.
    task automatic cyc(input logic av, input logic [5:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [5:0] ma, input logic [31:0] md,
                       input logic hold, input logic [5:0] r1, input logic [5:0] r2);
        logic e_a, e_m, f1v, f2v;
        logic [5:0] ga;
        logic [31:0] gd;
        wp_t e, g;
        A_Valid_In = av; A_Addr_In = aa; A_Data_In = ad;
        M_Valid_In = mv; M_Addr_In = ma; M_Data_In = md;
        Wr_Hold_In = hold; RS1_Addr_In = r1; RS2_Addr_In = r2;
        #1;
        e_a = av && !hold && (!mv || m_pri_a);
        e_m = mv && !hold && (!av || !m_pri_a);
        check_val("a_ready", A_Ready_Out, e_a);
        check_val("m_ready", M_Ready_Out, e_m);
        e = '0;
        if (e_a || e_m) begin
            ga = e_m ? ma : aa;
            gd = e_m ? md : ad;
            m_pri_a = e_m;
            if (ga >= 6'd32) begin
                e.err = 1'b1;
            end else if (ga != 6'd0) begin
                e.flag = 1'b1;
                m_cnt  = m_cnt + 16'd1;
                m_addr = ga;
                m_data = gd;
            end
        end
        e.addr = m_addr;
        e.data = m_data;
        e.cnt  = m_cnt;
        sb_q.push_back(e);
        @(posedge Clk_In);
        #1;
        g = sb_q.pop_front();
        check_val("wr_flag", Reg_Write_flag_Out, g.flag);
        check_val("err", Err_Out, g.err);
        check_val("rd_addr", RD_Addr_Out, g.addr);
        check_val("rd_data", RD_Data_Out, g.data);
        check_val("wr_count", Wr_Count_Out, g.cnt);
`ifdef REG_WRITE_BYPASS_EN
        f1v = g.flag && (r1 == g.addr) && (r1 != 6'd0);
        f2v = g.flag && (r2 == g.addr) && (r2 != 6'd0);
`else
        f1v = 1'b0;
        f2v = 1'b0;
`endif
        check_val("fwd1_valid", Fwd1_Valid_Out, f1v);
        check_val("fwd1_data", Fwd1_Data_Out, f1v ? g.data : 32'd0);
        check_val("fwd2_valid", Fwd2_Valid_Out, f2v);
        check_val("fwd2_data", Fwd2_Data_Out, f2v ? g.data : 32'd0);
        @(negedge Clk_In);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        Rst_In = 1'b1;
        A_Valid_In = 0; A_Addr_In = 0; A_Data_In = 0;
        M_Valid_In = 0; M_Addr_In = 0; M_Data_In = 0;
        Wr_Hold_In = 0; RS1_Addr_In = 0; RS2_Addr_In = 0;
        model_reset();
        #12;
        check_zero_outputs("reset");
        @(negedge Clk_In);
        Rst_In = 1'b0;

        // Single ALU request
        cyc(1, 6'd5, 32'h11, 0, 6'd0, 32'h0, 0, 6'd0, 6'd0);
        cyc(0, 6'd0, 32'h0, 0, 6'd0, 32'h0, 0, 6'd0, 6'd0);
        // Contention alternates M, A, M, A
        for (int i = 0; i < 4; i++)
            cyc(1, 6'd3, 32'hA000 + i, 1, 6'd4, 32'hB000 + i, 0, 6'd0, 6'd0);
        // Hold blocks both, then memory wins first
        for (int i = 0; i < 3; i++)
            cyc(1, 6'd3, 32'hA5, 1, 6'd4, 32'hB5, 1, 6'd0, 6'd0);
        cyc(1, 6'd3, 32'hA6, 1, 6'd4, 32'hB6, 0, 6'd0, 6'd0);
        cyc(0, 6'd0, 32'h0, 0, 6'd0, 32'h0, 0, 6'd0, 6'd0);
        // x0 write acknowledged but dropped; out-of-range write flags an error
        cyc(0, 6'd0, 32'h0, 1, 6'd0, 32'h77, 0, 6'd0, 6'd0);
        cyc(0, 6'd0, 32'h0, 1, 6'd40, 32'h88, 0, 6'd0, 6'd0);
        cyc(0, 6'd0, 32'h0, 1, 6'd31, 32'h99, 0, 6'd0, 6'd0);
        cyc(0, 6'd0, 32'h0, 1, 6'd32, 32'h9A, 0, 6'd0, 6'd0);
        // Bypass compare on the committed write
        cyc(1, 6'd7, 32'hDEAD, 0, 6'd0, 32'h0, 0, 6'd7, 6'd8);
        cyc(0, 6'd0, 32'h0, 0, 6'd0, 32'h0, 0, 6'd7, 6'd8);

        // Run the counter up to 0xFFFF, then one more write wraps it
        n = 32'hFFFF - int'(m_cnt);
        A_Valid_In = 1; A_Addr_In = 6'd1; A_Data_In = 32'h55;
        M_Valid_In = 0; Wr_Hold_In = 0; RS1_Addr_In = 0; RS2_Addr_In = 0;
        repeat (n) @(posedge Clk_In);
        #1;
        A_Valid_In = 0;
        m_cnt = m_cnt + 16'(n); m_addr = 6'd1; m_data = 32'h55; m_pri_a = 1'b0;
        check_val("cnt_max", Wr_Count_Out, 16'hFFFF);
        check_val("cnt_max_flag", Reg_Write_flag_Out, 1);
        @(negedge Clk_In);
        cyc(1, 6'd2, 32'h66, 0, 6'd0, 32'h0, 0, 6'd0, 6'd0);

        // Reset asserted while a grant is in progress
        A_Valid_In = 1; A_Addr_In = 6'd9; A_Data_In = 32'h99;
        #1;
        check_val("rst_grant_ready", A_Ready_Out, 1);
        #2;
        Rst_In = 1'b1;
        @(posedge Clk_In);
        #1;
        check_zero_outputs("mid_rst");
        @(negedge Clk_In);
        Rst_In = 1'b0;
        A_Valid_In = 0;
        model_reset();
        cyc(1, 6'd10, 32'hC1, 1, 6'd12, 32'hC2, 0, 6'd0, 6'd0);
        cyc(0, 6'd0, 32'h0, 0, 6'd0, 32'h0, 0, 6'd0, 6'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
